// File: rtl/icache_def.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_def;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_BITS  = LINE_WORDS * 16;

  typedef struct packed {
    logic                 valid;
    logic                 rw;
    logic [15:0]          addr;
    logic [LINE_BITS-1:0] data;
  } mem_req_type;

  typedef struct packed {
    logic                 ready;
    logic [LINE_BITS-1:0] data;
  } mem_data_type;

  typedef enum logic {IDLE, FILL} state_e;

  function automatic logic [15:0] word_sel(input logic [LINE_BITS-1:0] line,
                                           input logic [1:0]           off);
    return line[{off, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational read, one synchronous write port.
module icache_array
  import icache_def::*;
#(
  parameter int unsigned INDEX_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [13-INDEX_BITS:0] rd_tag,
  output logic [LINE_BITS-1:0]  rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [13-INDEX_BITS:0] wr_tag,
  input  logic [LINE_BITS-1:0]  wr_data
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid_q;
  logic [13-INDEX_BITS:0] tag_q  [LINES];
  logic [LINE_BITS-1:0]  data_q [LINES];

  // Only the valid bits are reset; tag and data are don't-care until valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller: same-cycle hits, blocking line fill.
module icache_ctrl
  import icache_def::*;
#(
  parameter int unsigned INDEX_BITS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetch_en,
  input  logic [15:0]  pc,
  output logic [15:0]  instr,
  output logic         instr_valid,
  output logic         stall,
  output mem_req_type  mem_req,
  input  mem_data_type mem_data_res
);

  localparam int unsigned TAG_BITS = 14 - INDEX_BITS;

  state_e        state_q, state_d;
  logic [15:0]   miss_addr_q, miss_addr_d;
  logic          hit;
  logic          fill_we;

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [LINE_BITS-1:0]  rd_data;

  logic [1:0]            pc_offset;
  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;

  assign pc_offset = pc[1:0];
  assign pc_index  = pc[INDEX_BITS+1:2];
  assign pc_tag    = pc[15:INDEX_BITS+2];

  icache_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (pc_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill_we),
    .wr_index (miss_addr_q[INDEX_BITS+1:2]),
    .wr_tag   (miss_addr_q[15:INDEX_BITS+2]),
    .wr_data  (mem_data_res.data)
  );

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill_we     = 1'b0;
    mem_req     = '0;

    // Lookups only happen in IDLE; a FILL cycle never reports a hit.
    hit         = fetch_en && (state_q == IDLE) && rd_valid && (rd_tag == pc_tag);
    instr_valid = hit;
    instr       = hit ? word_sel(rd_data, pc_offset) : 16'h0000;
    stall       = fetch_en && !hit;

    unique case (state_q)
      IDLE: begin
        // A ready pulse here is stale and deliberately ignored.
        if (fetch_en && !hit) begin
          miss_addr_d = {pc[15:2], 2'b00};
          state_d     = FILL;
        end
      end
      FILL: begin
        mem_req.valid = 1'b1;
        mem_req.rw    = 1'b0;
        mem_req.addr  = miss_addr_q;
        if (mem_data_res.ready) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench: stimulus queues expected hits and fill requests, a negedge monitor checks them.
module tb_icache_ctrl;
  import icache_def::*;

  localparam int unsigned IB = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_en;
  logic [15:0]  pc;
  logic [15:0]  instr;
  logic         instr_valid;
  logic         stall;
  mem_req_type  mem_req;
  mem_data_type mem_data_res;

  always #5 clk = ~clk;

  icache_ctrl #(
    .INDEX_BITS(IB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .pc           (pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_data_res (mem_data_res)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_instr_q[$];
  logic [15:0] exp_req_q[$];
  logic        prev_req_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented hit and every new fill request consumes one expectation.
  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (rst) begin
      prev_req_valid = 1'b0;
    end else begin
      if (instr_valid) begin
        if (exp_instr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hit: got instr %h at pc %h, expected no hit", instr, pc);
        end else begin
          e = exp_instr_q.pop_front();
          chk("instr", 64'(instr), 64'(e));
        end
      end
      if (mem_req.valid && !prev_req_valid) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h, expected no request", mem_req.addr);
        end else begin
          e = exp_req_q.pop_front();
          chk("req_hdr", 64'({mem_req.valid, mem_req.rw, mem_req.addr}), 64'({2'b10, e}));
          chk("req_data", mem_req.data, 64'h0);
        end
      end
      prev_req_valid = mem_req.valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_now(input logic [15:0] a, input logic [15:0] exp);
    fetch_en = 1'b1;
    pc       = a;
    exp_instr_q.push_back(exp);
    @(negedge clk);
    chk("hit_stall", 64'(stall), 64'h0);
    chk("hit_req_idle", 64'(mem_req.valid), 64'h0);
    step();
    fetch_en = 1'b0;
  endtask

  // Miss at cycle t, ready driven in cycle t+lat; returns at the start of cycle t+lat+1.
  task automatic do_miss(input logic [15:0] a, input int lat, input logic [63:0] line,
                         input bit early_ready);
    logic [15:0] la;
    int          stalls;
    la       = {a[15:2], 2'b00};
    stalls   = 0;
    fetch_en = 1'b1;
    pc       = a;
    exp_req_q.push_back(la);
    if (early_ready) begin
      mem_data_res.ready = 1'b1;
      mem_data_res.data  = 64'hDEAD_BEEF_DEAD_BEEF;
    end
    @(negedge clk);
    chk("miss_stall", 64'(stall), 64'h1);
    chk("miss_no_hit", 64'(instr_valid), 64'h0);
    chk("miss_req_not_yet", 64'(mem_req.valid), 64'h0);
    if (stall) stalls++;
    for (int k = 1; k <= lat; k++) begin
      step();
      mem_data_res.ready = (k == lat);
      mem_data_res.data  = (k == lat) ? line : 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      if (stall) stalls++;
      chk("fill_req_hdr", 64'({mem_req.valid, mem_req.rw, mem_req.addr}), 64'({2'b10, la}));
      chk("fill_no_hit", 64'(instr_valid), 64'h0);
    end
    step();
    mem_data_res.ready = 1'b0;
    chk("stall_cycles", 64'(stalls), 64'(lat + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    fetch_en     = 1'b0;
    pc           = 16'h0000;
    mem_data_res = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_instr_valid", 64'(instr_valid), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_instr", 64'(instr), 64'h0);
    chk("rst_mem_req_hdr", 64'({mem_req.valid, mem_req.rw, mem_req.addr}), 64'h0);
    chk("rst_mem_req_data", mem_req.data, 64'h0);
    step();

    // Cold miss, 4-cycle memory, then spatial hits in the same line
    do_miss(16'h0041, 4, 64'h4444_3333_2222_1111, 1'b0);
    hit_now(16'h0041, 16'h2222);
    hit_now(16'h0043, 16'h4444);
    hit_now(16'h0040, 16'h1111);

    // Conflict eviction on index 16
    do_miss(16'h00C0, 4, 64'hCCCC_BBBB_AAAA_9999, 1'b0);
    hit_now(16'h00C2, 16'hBBBB);
    do_miss(16'h0040, 4, 64'h5555_6666_7777_8888, 1'b0);
    hit_now(16'h0041, 16'h7777);

    // Long latency: ready 10 cycles after the miss
    do_miss(16'h0100, 10, 64'h0104_0103_0102_0101, 1'b0);
    hit_now(16'h0103, 16'h0104);

    // Reset in the 2nd FILL cycle
    fetch_en = 1'b1;
    pc       = 16'h0200;
    exp_req_q.push_back(16'h0200);
    @(negedge clk);
    chk("rf_miss_stall", 64'(stall), 64'h1);
    step();
    @(negedge clk);
    chk("rf_fill1_req", 64'(mem_req.valid), 64'h1);
    step();
    rst = 1'b1;
    step();
    rst      = 1'b0;
    fetch_en = 1'b0;
    @(negedge clk);
    chk("rf_req_dropped", 64'(mem_req.valid), 64'h0);
    chk("rf_stall", 64'(stall), 64'h0);
    step();
    mem_data_res.ready = 1'b1;
    mem_data_res.data  = 64'hFFFF_EEEE_DDDD_CCCC;
    @(negedge clk);
    chk("rf_late_ready_req", 64'(mem_req.valid), 64'h0);
    step();
    mem_data_res.ready = 1'b0;
    do_miss(16'h0041, 4, 64'h1234_5678_9ABC_DEF0, 1'b0);
    hit_now(16'h0041, 16'h9ABC);

    // PC change during FILL; also a ready pulse in the miss-detect cycle is ignored
    fetch_en           = 1'b1;
    pc                 = 16'h0010;
    mem_data_res.ready = 1'b1;
    mem_data_res.data  = 64'hDEAD_BEEF_DEAD_BEEF;
    exp_req_q.push_back(16'h0010);
    @(negedge clk);
    chk("pcc_miss_stall", 64'(stall), 64'h1);
    step();
    mem_data_res.ready = 1'b0;
    pc                 = 16'h0041;
    @(negedge clk);
    chk("pcc_no_hit_in_fill", 64'(instr_valid), 64'h0);
    chk("pcc_req_addr", 64'(mem_req.addr), 64'h0010);
    step();
    pc = 16'h0020;
    @(negedge clk);
    chk("pcc_req_addr_hold", 64'(mem_req.addr), 64'h0010);
    step();
    mem_data_res.ready = 1'b1;
    mem_data_res.data  = 64'h0013_0012_0011_0010;
    @(negedge clk);
    chk("pcc_stall_on_ready", 64'(stall), 64'h1);
    step();
    mem_data_res.ready = 1'b0;
    do_miss(16'h0020, 4, 64'h0023_0022_0021_0020, 1'b0);
    hit_now(16'h0021, 16'h0021);
    hit_now(16'h0012, 16'h0012);

    repeat (2) step();
    chk("instr_queue_drained", 64'(exp_instr_q.size()), 64'h0);
    chk("req_queue_drained", 64'(exp_req_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
